decoder_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2-to-4 decoded select resource between 4 requesters.
- Picks a winner index and drives the enabled 2-to-4 decode to produce a one-hot grant.
- Holds the grant until the winner releases or a hold timeout preempts it.
- Sits in front of any 4-way shared resource: bus, memory port or output mux.

---
 rtl/decoder_arb_pkg.sv | 25 ++
 rtl/dec2to4.sv | 14 +
 rtl/decoder_rr_arbiter.sv | 92 +++++++++
 tb/tb_decoder_rr_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin decoded-grant arbiter.
package decoder_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Circular first-set search starting at ptr. Offsets are scanned from the
  // far end back toward ptr so the closest set bit is the last one written.
  // The result is only meaningful when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/dec2to4.sv
// Enabled 2-to-4 one-hot decoder; output is zero when disabled.
module dec2to4 (
  input  logic [1:0] A,
  input  logic       E,
  output logic [3:0] Y
);

  // Shift a single one into position A when enabled.
  always_comb begin
    Y = 4'b0000;
    if (E) Y = 4'b0001 << A;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for one 4-way shared resource. The grant is held until
// the owner drops its request, or until HOLD_MAX cycles have elapsed while
// someone else is waiting. One dead cycle always separates two grants.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant; next non-zero req is arbitrated from ptr_q onward
//   GRANT | idx_q owns the resource; hold_q counts cycles of ownership
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam int               HC_W       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HC_W-1:0]  HOLD_LAST  = (HOLD_MAX > 0) ? HC_W'(HOLD_MAX - 1) : '0;
  localparam bit               PREEMPT_EN = (HOLD_MAX != 0);

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [HC_W-1:0]  hold_q;
  logic             valid_q;

  logic [IDX_W-1:0] pick_d;
  logic [IDX_W-1:0] ptr_d;
  logic [HC_W-1:0]  hold_d;
  logic             others_wait;
  logic             rearb;

  // gnt is already the one-hot of idx_q during GRANT, so it doubles as the
  // owner mask when looking for other waiting requesters.
  always_comb begin
    pick_d      = rr_pick(req, ptr_q);
    ptr_d       = idx_q + 1'b1;
    hold_d      = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
    others_wait = |(req & ~gnt);
    rearb       = !req[idx_q] || (PREEMPT_EN && (hold_q == HOLD_LAST) && others_wait);
  end

  // Arbitration FSM with registered grant index and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            idx_q   <= pick_d;
            valid_q <= 1'b1;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (rearb) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ptr_q   <= ptr_d;
          end else begin
            hold_q  <= hold_d;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  dec2to4 u_dec (
    .A (idx_q),
    .E (valid_q),
    .Y (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: three instances (HOLD_MAX 4, 0, 1) share the
// same request stream and are compared cycle by cycle against a tenure-based
// reference model, plus directed scenarios with fixed expected grants.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] g   [3];
  logic [1:0] gi  [3];
  logic       gv  [3];

  int hm_tab [3];
  int n_chk  = 0;
  int n_pass = 0;

  // reference model state per instance
  int m_valid [3];
  int m_idx   [3];
  int m_start [3];
  int m_ten   [3];

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.HOLD_MAX(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .gnt(g[0]), .gnt_idx(gi[0]), .gnt_valid(gv[0]));
  decoder_rr_arbiter #(.HOLD_MAX(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req), .gnt(g[1]), .gnt_idx(gi[1]), .gnt_valid(gv[1]));
  decoder_rr_arbiter #(.HOLD_MAX(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .gnt(g[2]), .gnt_idx(gi[2]), .gnt_valid(gv[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0;
      m_idx[i]   = 0;
      m_start[i] = 0;
      m_ten[i]   = 0;
    end
  endfunction

  // One rising edge of the specified behaviour, in terms of tenure length.
  function automatic void model_edge(input logic [3:0] r);
    int others;
    bit found;
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i] == 0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && r[(m_start[i] + k) % 4]) begin
            found      = 1'b1;
            m_idx[i]   = (m_start[i] + k) % 4;
            m_valid[i] = 1;
            m_ten[i]   = 1;
          end
        end
      end else begin
        others = int'(r) & ~(1 << m_idx[i]);
        if (!r[m_idx[i]] || (hm_tab[i] != 0 && m_ten[i] >= hm_tab[i] && others != 0)) begin
          m_valid[i] = 0;
          m_start[i] = (m_idx[i] + 1) % 4;
        end else begin
          m_ten[i] = m_ten[i] + 1;
        end
      end
    end
  endfunction

  task automatic check_all();
    int eg;
    for (int i = 0; i < 3; i++) begin
      eg = (m_valid[i] != 0) ? (1 << m_idx[i]) : 0;
      check($sformatf("gnt_hm%0d", hm_tab[i]),   int'(g[i]),  eg);
      check($sformatf("valid_hm%0d", hm_tab[i]), int'(gv[i]), m_valid[i]);
      check($sformatf("idx_hm%0d", hm_tab[i]),   int'(gi[i]), m_idx[i]);
    end
  endtask

  // Called just after a falling edge: drive req, take the rising edge, check.
  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(req);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset with all requests high; outputs must clear at once.
  task automatic do_reset();
    #2;
    req = 4'b1111;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_async_gnt",   int'(g[i]),  0);
      check("rst_async_valid", int'(gv[i]), 0);
      check("rst_async_idx",   int'(gi[i]), 0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    int pos;
    hm_tab = '{4, 0, 1};
    model_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0000);
    check("idle_quiet", int'(g[0]), 0);

    // Reset then full contention: order 0,1,2,3,0 with 4-cycle tenures.
    cyc(4'b1111);
    cyc(4'b1111);
    do_reset();
    for (int c = 1; c <= 21; c++) begin
      cyc(4'b1111);
      pos = (c - 1) % 5;
      check($sformatf("contend_c%0d", c), int'(g[0]),
            (pos == 4) ? 0 : (1 << (((c - 1) / 5) % 4)));
    end
    check("contend_h0_owner", int'(g[1]), 1);

    // Single requester, drop, then wrap search from ptr=3 to index 0.
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      cyc(4'b0100);
      check("single_gnt", int'(g[0]), 4'b0100);
      check("single_idx", int'(gi[0]), 2);
    end
    cyc(4'b0000);
    check("single_drop", int'(g[0]), 0);
    cyc(4'b0001);
    check("single_wrap", int'(g[0]), 4'b0001);

    // Lone holder is never preempted.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      cyc(4'b0001);
      check($sformatf("lone_c%0d", c), int'(g[0]), 4'b0001);
    end

    // Wrap and masking: index 3 is served before index 1 after index 2.
    do_reset();
    cyc(4'b0100);
    check("wrap_own2", int'(g[0]), 4'b0100);
    cyc(4'b1011);
    check("wrap_dead1", int'(g[0]), 0);
    cyc(4'b1011);
    check("wrap_gnt3", int'(g[0]), 4'b1000);
    cyc(4'b0011);
    check("wrap_dead2", int'(g[0]), 0);
    cyc(4'b0011);
    check("wrap_gnt0", int'(g[0]), 4'b0001);

    // HOLD_MAX=0 never preempts even with others waiting.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      cyc(4'b0011);
      check("nohold_gnt", int'(g[1]), 4'b0001);
    end
    cyc(4'b0010);
    check("nohold_dead", int'(g[1]), 0);
    cyc(4'b0010);
    check("nohold_next", int'(g[1]), 4'b0010);

    // Randomized traffic with sticky requests and rare resets.
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
